execute_cycle: RTL

EXECUTE_CYCLE -- requirements
Module: execute_cycle

---
 rtl/execute_cycle_pkg.sv | 49 ++++
 rtl/execute_cycle_alu.sv | 26 ++
 rtl/execute_cycle.sv | 86 ++++++++
 3 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared encodings and the EX/MEM payload for the execute stage.
package execute_cycle_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [REGW-1:0] rd;
    } ex_mem_t;

    // Operand bypass select; the unused 11 code falls back to the register file value.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                 input logic [XLEN-1:0] rf_v,
                                                 input logic [XLEN-1:0] wb_v,
                                                 input logic [XLEN-1:0] mem_v);
        case (sel)
            FWD_WB:  return wb_v;
            FWD_MEM: return mem_v;
            default: return rf_v;
        endcase
    endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// 32-bit ALU: add, sub, and, or, signed set-less-than; other codes yield 0.
module alu
    import execute_cycle_pkg::*;
(
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = XLEN'($signed(A) < $signed(B));
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [31:0]     RD1_E,
    input  logic [31:0]     RD2_E,
    input  logic [31:0]     Imm_Ext_E,
    input  logic [31:0]     PCE,
    input  logic [31:0]     PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [31:0]     ResultW,
    output logic            PCSrcE,
    output logic [31:0]     PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [31:0]     ALUResultM,
    output logic [31:0]     WriteDataM,
    output logic [31:0]     PCPlus4M,
    output logic [4:0]      RD_M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    ex_mem_t         m_d;
    ex_mem_t         m_q;

    // MEM-stage bypass uses the value currently held in the EX/MEM register.
    assign src_a = fwd_mux(ForwardA_E, RD1_E, ResultW, m_q.alu_result);
    assign fwd_b = fwd_mux(ForwardB_E, RD2_E, ResultW, m_q.alu_result);
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (BranchE & zero) | JumpE;

    // Store data is the forwarded rs2 value, not the immediate-muxed operand.
    always_comb begin
        m_d            = '0;
        m_d.reg_write  = RegWriteE;
        m_d.mem_write  = MemWriteE;
        m_d.result_src = ResultSrcE;
        m_d.alu_result = alu_result;
        m_d.write_data = fwd_b;
        m_d.pc_plus4   = PCPlus4E;
        m_d.rd         = RD_E;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
        end else begin
            m_q <= m_d;
        end
    end

    assign RegWriteM  = m_q.reg_write;
    assign MemWriteM  = m_q.mem_write;
    assign ResultSrcM = m_q.result_src;
    assign ALUResultM = m_q.alu_result;
    assign WriteDataM = m_q.write_data;
    assign PCPlus4M   = m_q.pc_plus4;
    assign RD_M       = m_q.rd;

endmodule
